// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control logic: FSM encoding, trap cause
// codes and parameter defaults.
package cpu_ctrl_pkg;

  // Hazard controller states: normal issue, or a multi-cycle bubble train.
  typedef enum logic {
    StRun   = 1'b0,
    StStall = 1'b1
  } ctrl_state_e;

  // Trap cause codes reported on trap_cause.
  localparam logic CauseUndef = 1'b0;
  localparam logic CauseIrq   = 1'b1;

  // Parameter defaults.
  localparam int unsigned DefRegW       = 5;
  localparam int unsigned DefLoadStall  = 1;
  localparam int unsigned DefBranchInId = 1;

endpackage

// File: rtl/hazard_match.sv
// Source/destination register comparator for one producing pipeline stage.
// Hits when the ID instruction really reads a register that the producer
// writes; r0 never creates a dependency.
module hazard_match
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = DefRegW
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] prod_wreg,
  output logic             hit
);

  logic rs_hit;
  logic rt_hit;

  // Per-operand compare gated by the use flags, then qualified by a real
  // instruction and a non-zero destination.
  always_comb begin
    rs_hit = id_use_rs && (id_rs == prod_wreg);
    rt_hit = id_use_rt && (id_rt == prod_wreg);
    hit    = id_valid && (prod_wreg != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and trap controller. Computes how many bubbles the ID
// instruction needs, inserts them (first one combinationally, the rest from a
// small down-counter), and arbitrates the undefined-instruction and interrupt
// traps against stalls and redirects.
module hazard_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned REG_W        = DefRegW,
  parameter int unsigned LOAD_STALL   = DefLoadStall,
  parameter int unsigned BRANCH_IN_ID = DefBranchInId
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_branch,
  input  logic             id_undef,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             irq_req,
  input  logic             in_kernel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             trap_take,
  output logic             trap_cause,
  output logic             irq_ack
);

  // Wide enough to hold the longest requirement, LOAD_STALL + 1.
  localparam int unsigned CNT_W   = $clog2(LOAD_STALL + 2);
  localparam bit          BrInId  = (BRANCH_IN_ID != 0);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_pending_q, irq_pending_d;

  logic             hit_ex;
  logic             hit_mem;
  logic             br_chk;
  logic [CNT_W-1:0] need;
  logic             irq_taken;

  hazard_match #(
    .REG_W(REG_W)
  ) u_match_ex (
    .id_valid (id_valid),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .prod_wreg(ex_wreg),
    .hit      (hit_ex)
  );

  hazard_match #(
    .REG_W(REG_W)
  ) u_match_mem (
    .id_valid (id_valid),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .prod_wreg(mem_wreg),
    .hit      (hit_mem)
  );

  // Stall requirement: later assignments are the larger values, so the last
  // one that applies is the maximum.
  always_comb begin
    br_chk = BrInId && id_is_branch;
    need   = '0;
    if (br_chk && mem_mem_read && hit_mem) begin
      need = CNT_W'(1);
    end
    if (br_chk && ex_reg_write && !ex_mem_read && hit_ex) begin
      need = CNT_W'(1);
    end
    if (ex_mem_read && hit_ex) begin
      need = br_chk ? CNT_W'(LOAD_STALL + 1) : CNT_W'(LOAD_STALL);
    end
  end

  // Next-state and outputs. The first bubble is issued from RUN with zero
  // latency; STALL only covers bubbles two onwards.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    trap_take    = 1'b0;
    trap_cause   = CauseUndef;
    irq_ack      = 1'b0;
    irq_taken    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (id_valid && id_undef) begin
          trap_take    = 1'b1;
          trap_cause   = CauseUndef;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (need != '0) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (need > CNT_W'(1)) begin
            state_d = StStall;
            cnt_d   = need - CNT_W'(2);
          end
        end else if (irq_pending_q && !in_kernel && !id_is_branch && !jump && !id_undef) begin
          // Only at a clean boundary, so EPC never points into a branch shadow.
          trap_take    = 1'b1;
          trap_cause   = CauseIrq;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          irq_ack      = 1'b1;
          irq_taken    = 1'b1;
        end else begin
          if_id_flush = branch_taken | jump;
        end
      end
      StStall: begin
        // Redirects and traps are deliberately ignored until back in RUN.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // A new request wins over a simultaneous acknowledge.
    irq_pending_d = irq_req | (irq_pending_q & ~irq_taken);
  end

  // State, bubble counter and pending interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      cnt_q         <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      irq_pending_q <= irq_pending_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. Two instances share every input: dut_a with
// LOAD_STALL=1 and dut_b with LOAD_STALL=2. Each cycle the stimulus pushes the
// hand-derived output vectors for both into a scoreboard; the negedge monitor
// pops and compares. Vector order:
// {pc_write, if_id_write, if_id_flush, id_ex_bubble, trap_take, trap_cause, irq_ack}
module tb_hazard_stall_ctrl;

  localparam logic [6:0] RunO  = 7'b1100000;
  localparam logic [6:0] StlO  = 7'b0001000;
  localparam logic [6:0] FluO  = 7'b1110000;
  localparam logic [6:0] TrapU = 7'b1111100;
  localparam logic [6:0] TrapI = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt;
  logic       id_is_branch, id_undef;
  logic       branch_taken, jump;
  logic       ex_reg_write, ex_mem_read;
  logic [4:0] ex_wreg;
  logic       mem_mem_read;
  logic [4:0] mem_wreg;
  logic       irq_req, in_kernel;

  logic a_pcw, a_ifw, a_flu, a_bub, a_trp, a_cau, a_ack;
  logic b_pcw, b_ifw, b_flu, b_bub, b_trp, b_cau, b_ack;
  logic [6:0] out_a, out_b;

  assign out_a = {a_pcw, a_ifw, a_flu, a_bub, a_trp, a_cau, a_ack};
  assign out_b = {b_pcw, b_ifw, b_flu, b_bub, b_trp, b_cau, b_ack};

  typedef struct {
    string      tag;
    logic [6:0] ea;
    logic [6:0] eb;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  hazard_stall_ctrl #(
    .REG_W(5), .LOAD_STALL(1), .BRANCH_IN_ID(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_undef(id_undef), .branch_taken(branch_taken), .jump(jump),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg),
    .mem_mem_read(mem_mem_read), .mem_wreg(mem_wreg), .irq_req(irq_req),
    .in_kernel(in_kernel), .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_flu),
    .id_ex_bubble(a_bub), .trap_take(a_trp), .trap_cause(a_cau), .irq_ack(a_ack)
  );

  hazard_stall_ctrl #(
    .REG_W(5), .LOAD_STALL(2), .BRANCH_IN_ID(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_undef(id_undef), .branch_taken(branch_taken), .jump(jump),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_wreg(ex_wreg),
    .mem_mem_read(mem_mem_read), .mem_wreg(mem_wreg), .irq_req(irq_req),
    .in_kernel(in_kernel), .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_flu),
    .id_ex_bubble(b_bub), .trap_take(b_trp), .trap_cause(b_cau), .irq_ack(b_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: outputs are sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, "/a"}, out_a, e.ea);
      check_eq({e.tag, "/b"}, out_b, e.eb);
    end
  end

  task automatic expect_out(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    exp_t e;
    e.tag = tag;
    e.ea  = ea;
    e.eb  = eb;
    sb_q.push_back(e);
  endtask

  task automatic clr();
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_is_branch = 0; id_undef = 0; branch_taken = 0; jump = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_wreg = '0;
    mem_mem_read = 0; mem_wreg = '0; irq_req = 0; in_kernel = 0;
  endtask

  // Start a new cycle just after the clock edge with all inputs idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic id_rs_use(input logic [4:0] r);
    id_valid = 1; id_rs = r; id_use_rs = 1;
  endtask

  task automatic ex_load(input logic [4:0] r);
    ex_mem_read = 1; ex_reg_write = 1; ex_wreg = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr();

    tick(); expect_out("rst_hold", RunO, RunO);
    tick(); rst_n = 1'b1; expect_out("rst_rel", RunO, RunO);

    // Load-use on rs, non-branch consumer.
    tick(); id_rs_use(8); ex_load(8); expect_out("lduse_c1", StlO, StlO);
    tick(); id_rs_use(8); mem_mem_read = 1; mem_wreg = 8; expect_out("lduse_c2", RunO, StlO);
    tick(); id_rs_use(8); expect_out("lduse_c3", RunO, RunO);

    // Load-use on rt.
    tick(); id_valid = 1; id_rt = 9; id_use_rt = 1; ex_load(9); expect_out("ldrt_c1", StlO, StlO);
    tick(); expect_out("ldrt_c2", RunO, StlO);
    tick(); expect_out("ldrt_c3", RunO, RunO);

    // Use flag and id_valid gate the match.
    tick(); id_valid = 1; id_rs = 8; ex_load(8); expect_out("nouse", RunO, RunO);
    tick(); id_rs = 8; id_use_rs = 1; ex_load(8); expect_out("novalid", RunO, RunO);

    // Load feeding a branch; taken is held but ignored while stalling.
    tick(); id_rs_use(8); id_is_branch = 1; branch_taken = 1; ex_load(8);
    expect_out("ldbr_c1", StlO, StlO);
    tick(); id_rs_use(8); id_is_branch = 1; branch_taken = 1; mem_mem_read = 1; mem_wreg = 8;
    expect_out("ldbr_c2", StlO, StlO);
    tick(); id_rs_use(8); id_is_branch = 1; branch_taken = 1; expect_out("ldbr_c3", FluO, StlO);
    tick(); id_rs_use(8); id_is_branch = 1; branch_taken = 1; expect_out("ldbr_c4", FluO, FluO);

    // r0 producers never stall.
    tick(); id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_is_branch = 1;
    ex_reg_write = 1; expect_out("r0_alu", RunO, RunO);
    tick(); id_valid = 1; id_use_rs = 1; id_use_rt = 1; id_is_branch = 1;
    ex_load(0); mem_mem_read = 1; expect_out("r0_load", RunO, RunO);

    // Single-cycle branch hazards, and their absence for non-branches.
    tick(); id_rs_use(5); id_is_branch = 1; ex_reg_write = 1; ex_wreg = 5;
    expect_out("alu_br", StlO, StlO);
    tick(); id_rs_use(5); id_is_branch = 1; expect_out("br_clean", RunO, RunO);
    tick(); id_rs_use(5); id_is_branch = 1; mem_mem_read = 1; mem_wreg = 5;
    expect_out("mem_br", StlO, StlO);
    tick(); id_rs_use(5); mem_mem_read = 1; mem_wreg = 5; expect_out("mem_nonbr", RunO, RunO);
    tick(); id_rs_use(5); ex_reg_write = 1; ex_wreg = 5; expect_out("alu_nonbr", RunO, RunO);

    // Interrupt arriving mid-stall waits for RUN.
    tick(); id_rs_use(8); id_is_branch = 1; ex_load(8); expect_out("irqst_c1", StlO, StlO);
    tick(); irq_req = 1; expect_out("irqst_c2", StlO, StlO);
    tick(); expect_out("irqst_c3", TrapI, StlO);
    tick(); expect_out("irqst_c4", RunO, TrapI);
    tick(); expect_out("irqst_c5", RunO, RunO);

    // Kernel mode masks a pending interrupt.
    tick(); irq_req = 1; expect_out("kern_c1", RunO, RunO);
    tick(); in_kernel = 1; expect_out("kern_c2", RunO, RunO);
    tick(); in_kernel = 1; expect_out("kern_c3", RunO, RunO);
    tick(); expect_out("kern_c4", TrapI, TrapI);
    tick(); expect_out("kern_c5", RunO, RunO);

    // Jump and branch in ID defer a pending interrupt.
    tick(); irq_req = 1; expect_out("jmp_c1", RunO, RunO);
    tick(); jump = 1; expect_out("jmp_c2", FluO, FluO);
    tick(); id_valid = 1; id_is_branch = 1; expect_out("jmp_c3", RunO, RunO);
    tick(); expect_out("jmp_c4", TrapI, TrapI);
    tick(); expect_out("jmp_c5", RunO, RunO);

    // Undefined instruction beats a load-use hazard and a pending irq.
    tick(); irq_req = 1; expect_out("undef_c1", RunO, RunO);
    tick(); id_rs_use(8); id_undef = 1; ex_load(8); expect_out("undef_c2", TrapU, TrapU);
    tick(); expect_out("undef_c3", TrapI, TrapI);
    tick(); expect_out("undef_c4", RunO, RunO);

    // Undefined instruction is held off while stalling.
    tick(); id_rs_use(8); id_is_branch = 1; ex_load(8); expect_out("undst_c1", StlO, StlO);
    tick(); id_valid = 1; id_undef = 1; expect_out("undst_c2", StlO, StlO);
    tick(); id_valid = 1; id_undef = 1; expect_out("undst_c3", TrapU, StlO);
    tick(); expect_out("undst_c4", RunO, RunO);

    // Reset in the middle of a stall drops bubbles and the pending irq.
    tick(); id_rs_use(8); id_is_branch = 1; ex_load(8); irq_req = 1;
    expect_out("rstst_c1", StlO, StlO);
    tick(); rst_n = 1'b0; expect_out("rstst_c2", RunO, RunO);
    tick(); rst_n = 1'b1; expect_out("rstst_c3", RunO, RunO);
    tick(); expect_out("rstst_c4", RunO, RunO);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
